// File: rtl/eth_sw_pkg.sv
// Shared helpers for the N-port switch: destination decode, round-robin pick, drop saturation value.
// Pure functions and constants only; no latency, no flow control.
package eth_sw_pkg;
  localparam int MAX_DATA_W = 64;
  localparam int MAX_PORTS = 8;
  localparam int IDX_W = 3;
  localparam int DROP_MAX_W = 32;
  localparam logic [DROP_MAX_W-1:0] DROP_MAX = '1;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  function automatic logic [IDX_W-1:0] dest_of(input logic [MAX_DATA_W-1:0] word,
                                               input int data_w, input int addr_w);
    logic [MAX_DATA_W-1:0] v_shifted;
    logic [IDX_W-1:0]      v_mask;
    v_shifted = word >> (data_w - addr_w);
    v_mask    = IDX_W'((1 << addr_w) - 1);
    return v_shifted[IDX_W-1:0] & v_mask;
  endfunction

  // Scans from the highest offset down so the lowest offset from ptr wins.
  function automatic rr_pick_t rr_pick(input logic [MAX_PORTS-1:0] req,
                                       input logic [IDX_W-1:0] ptr, input int nports);
    rr_pick_t v_res;
    int       v_c;
    v_res = '0;
    for (int k = nports - 1; k >= 0; k--) begin
      v_c = int'(ptr) + k;
      if (v_c >= nports) v_c = v_c - nports;
      if (req[v_c[IDX_W-1:0]]) begin
        v_res.found = 1'b1;
        v_res.idx   = v_c[IDX_W-1:0];
      end
    end
    return v_res;
  endfunction
endpackage

// File: rtl/eth_sw_fifo.sv
// Per-output word FIFO, head visible one cycle after push (no bypass).
// Backpressure: full blocks push even when a pop happens in the same cycle.
module eth_sw_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_wr_en;
  logic              w_rd_en;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr_en   = push & ~full;
  assign w_rd_en   = pop & ~empty;
  // Zero when empty so the output bus reads 0 out of reset.
  assign head_data = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/eth_switch_nport.sv
// N-port store-and-forward word switch: per-output RR arbiter into per-output FIFO, 1-cycle min latency.
// Backpressure: in_ready only for the granted input per output; invalid destinations are always consumed and counted.
module eth_switch_nport
  import eth_sw_pkg::*;
#(
  parameter int NPORTS     = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPORTS-1:0]        in_valid,
  input  logic [NPORTS*DATA_W-1:0] in_data,
  output logic [NPORTS-1:0]        in_ready,
  output logic [NPORTS-1:0]        out_valid,
  output logic [NPORTS*DATA_W-1:0] out_data,
  input  logic [NPORTS-1:0]        out_ready,
  output logic [DROP_W-1:0]        drop_cnt
);
  localparam int ADDR_W = (NPORTS > 2) ? $clog2(NPORTS) : 1;
  localparam int SUM_W  = DROP_W + 4;
  localparam logic [DROP_W-1:0] DROP_SAT = DROP_MAX[DROP_W-1:0];

  logic [IDX_W-1:0]  r_rr_ptr [NPORTS];
  logic [DROP_W-1:0] r_drop_cnt;

  logic [IDX_W-1:0]  w_dest [NPORTS];
  logic [NPORTS-1:0] w_dest_ok;
  logic [NPORTS-1:0] w_grant;
  logic [NPORTS-1:0] w_full;
  logic [NPORTS-1:0] w_empty;
  logic [IDX_W-1:0]  w_grant_idx [NPORTS];
  logic [DATA_W-1:0] w_push_data [NPORTS];
  logic [DATA_W-1:0] w_head [NPORTS];
  logic [3:0]        w_drop_inc;
  logic [SUM_W-1:0]  w_drop_sum;

  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      w_dest[i]    = dest_of(MAX_DATA_W'(in_data[i*DATA_W +: DATA_W]), DATA_W, ADDR_W);
      w_dest_ok[i] = (int'(w_dest[i]) < NPORTS);
    end
  end

  always_comb begin
    logic [NPORTS-1:0] v_req;
    rr_pick_t          v_pick;
    in_ready   = '0;
    w_drop_inc = '0;
    for (int j = 0; j < NPORTS; j++) begin
      v_req = '0;
      for (int i = 0; i < NPORTS; i++) begin
        v_req[i] = in_valid[i] & w_dest_ok[i] & (w_dest[i] == IDX_W'(j));
      end
      v_pick         = rr_pick(MAX_PORTS'(v_req), r_rr_ptr[j], NPORTS);
      w_grant[j]     = v_pick.found & ~w_full[j] & ~reset;
      w_grant_idx[j] = v_pick.idx;
      w_push_data[j] = '0;
      for (int i = 0; i < NPORTS; i++) begin
        if (v_pick.idx == IDX_W'(i)) begin
          w_push_data[j] = in_data[i*DATA_W +: DATA_W];
          if (w_grant[j]) in_ready[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < NPORTS; i++) begin
      if (in_valid[i] & ~w_dest_ok[i] & ~reset) begin
        in_ready[i] = 1'b1;
        w_drop_inc  = w_drop_inc + 4'd1;
      end
    end
    w_drop_sum = SUM_W'(r_drop_cnt) + SUM_W'(w_drop_inc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NPORTS; j++) r_rr_ptr[j] <= '0;
      r_drop_cnt <= '0;
    end else begin
      for (int j = 0; j < NPORTS; j++) begin
        if (w_grant[j]) begin
          r_rr_ptr[j] <= (int'(w_grant_idx[j]) == NPORTS - 1) ? '0 : w_grant_idx[j] + IDX_W'(1);
        end
      end
      if (w_drop_sum > SUM_W'(DROP_SAT)) r_drop_cnt <= DROP_SAT;
      else                               r_drop_cnt <= w_drop_sum[DROP_W-1:0];
    end
  end

  for (genvar j = 0; j < NPORTS; j++) begin : g_out
    eth_sw_fifo #(
      .DATA_W(DATA_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (w_grant[j]),
      .push_data(w_push_data[j]),
      .full     (w_full[j]),
      .pop      (out_ready[j]),
      .head_data(w_head[j]),
      .empty    (w_empty[j])
    );
    assign out_valid[j]                 = ~w_empty[j];
    assign out_data[j*DATA_W +: DATA_W] = w_head[j];
  end

  assign drop_cnt = r_drop_cnt;
endmodule
